// File: rtl/scsi_bus_transfer_controller.sv
// -----------------------------------------------------------------------------
// ScsiBusTransferController (module scsi_bus_transfer_controller)
//
// Purpose:
//   Sequences single-byte SCSI data-phase transfers between the host data
//   register and the external SCSI bus. Runs the initiator side of the
//   nREQ/nACK handshake and drives the OE / nInvertFlag controls of the two
//   inverter buffers (tx = internal->external, rx = external->internal).
//   Sits between the host bus decode and the bidirectional pad control.
//
// Parameters:
//   SETUP_CYCLES    clocks data is driven on the bus before nACK asserts (1..15)
//   TIMEOUT_CYCLES  clocks allowed in an ACK wait state before abort (12-bit)
//
// Ports:
//   clock_i          system clock, rising edge
//   nReset_i         asynchronous active-low reset
//   hostWrite_i      one-clock pulse, host writes the data register
//   hostRead_i       one-clock pulse, host read of the data register completes
//   hostDataIn_i     host write data
//   rxData_i         rx inverter Q (external bus, already de-inverted)
//   nREQ_i           SCSI REQ, active low, pre-synchronised
//   IO_i             SCSI I/O: 1 = target->host, 0 = host->target
//   clearError_i     one-clock pulse, clears the sticky error flag(s)
//   nACK_o           SCSI ACK, active low
//   txOE_o           tx inverter output enable
//   txNInvert_o      tx inverter nInvertFlag (always 0)
//   rxOE_o           rx inverter output enable
//   rxNInvert_o      rx inverter nInvertFlag (always 0)
//   dataReg_o        data register (host read value / tx inverter D)
//   dataValid_o      data register holds an untransferred byte
//   busy_o           controller is not idle
//   timeoutError_o   sticky handshake timeout flag
//
// Optional feature (macro BEEBSCSI_PARITY_EN):
//   dbPOut_o         odd parity of dataReg, meaningful while txOE_o = 1
//   dbPIn_i          parity bit from the bus, checked on capture
//   parityError_o    sticky parity error, cleared by clearError_i
// -----------------------------------------------------------------------------
module scsi_bus_transfer_controller #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic       clock_i,
  input  logic       nReset_i,
  input  logic       hostWrite_i,
  input  logic       hostRead_i,
  input  logic [7:0] hostDataIn_i,
  input  logic [7:0] rxData_i,
  input  logic       nREQ_i,
  input  logic       IO_i,
  input  logic       clearError_i,
  output logic       nACK_o,
  output logic       txOE_o,
  output logic       txNInvert_o,
  output logic       rxOE_o,
  output logic       rxNInvert_o,
  output logic [7:0] dataReg_o,
  output logic       dataValid_o,
  output logic       busy_o,
`ifdef BEEBSCSI_PARITY_EN
  output logic       dbPOut_o,
  input  logic       dbPIn_i,
  output logic       parityError_o,
`endif
  output logic       timeoutError_o
);

  // One counter serves both the setup delay and the ACK-phase timeout; the
  // two uses never overlap, so it is cleared on every state change.
  localparam int unsigned CountWidth = 12;
  localparam logic [CountWidth-1:0] SetupLast   = CountWidth'(SETUP_CYCLES - 1);
  localparam logic [CountWidth-1:0] TimeoutLast = CountWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    OUT_SETUP,
    OUT_ACK,
    OUT_RELEASE,
    IN_CAPTURE,
    IN_ACK
  } state_e;

  state_e                state_q,        state_d;
  logic [CountWidth-1:0] count_q,        count_d;
  logic [7:0]            dataReg_q,      dataReg_d;
  logic                  dataValid_q,    dataValid_d;
  logic                  timeoutError_q, timeoutError_d;
  logic                  nAck_q,         nAck_d;
  logic                  txOE_q,         txOE_d;
  logic                  rxOE_q,         rxOE_d;

  // State and output registers. The pad controls are registered so the
  // buffers and the SCSI ACK line never see decode glitches; they are
  // computed from the next state, so they change on the same edge as the
  // state itself. Reset drops everything immediately, losing any byte that
  // was in flight.
  always_ff @(posedge clock_i or negedge nReset_i) begin
    if (!nReset_i) begin
      state_q        <= IDLE;
      count_q        <= '0;
      dataReg_q      <= 8'h00;
      dataValid_q    <= 1'b0;
      timeoutError_q <= 1'b0;
      nAck_q         <= 1'b1;
      txOE_q         <= 1'b0;
      rxOE_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      dataReg_q      <= dataReg_d;
      dataValid_q    <= dataValid_d;
      timeoutError_q <= timeoutError_d;
      nAck_q         <= nAck_d;
      txOE_q         <= txOE_d;
      rxOE_q         <= rxOE_d;
    end
  end

  // Next-state logic for the transfer sequencer.
  // IDLE owns the host interface: writes only land when the register is
  // empty, and a pending byte or an empty register decides which direction
  // a target request may start. IO is only looked at here, so a target
  // flipping it mid-transfer has no effect until the next IDLE.
  // Both ACK states share the timeout: a target that never releases REQ
  // sends us back to IDLE with the sticky error set, leaving dataValid as
  // it was so the host can see whether the byte went out. The error clear
  // is applied first so that a timeout on the same edge overrides it.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    dataReg_d      = dataReg_q;
    dataValid_d    = dataValid_q;
    timeoutError_d = timeoutError_q;

    if (clearError_i) begin
      timeoutError_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (hostWrite_i && !dataValid_q) begin
          dataReg_d   = hostDataIn_i;
          dataValid_d = 1'b1;
        end else if (hostRead_i) begin
          dataValid_d = 1'b0;
        end
        if (!timeoutError_q && !nREQ_i) begin
          if (dataValid_q && !IO_i) begin
            state_d = OUT_SETUP;
          end else if (!dataValid_q && IO_i) begin
            state_d = IN_CAPTURE;
          end
        end
      end

      OUT_SETUP: begin
        if (count_q == SetupLast) begin
          state_d = OUT_ACK;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      OUT_ACK, IN_ACK: begin
        if (nREQ_i) begin
          state_d = (state_q == OUT_ACK) ? OUT_RELEASE : IDLE;
          count_d = '0;
        end else if (count_q == TimeoutLast) begin
          state_d        = IDLE;
          count_d        = '0;
          timeoutError_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      // One extra clock with the tx buffer still driving and ACK released
      // gives the target its data hold time.
      OUT_RELEASE: begin
        dataValid_d = 1'b0;
        state_d     = IDLE;
      end

      // The rx buffer is enabled for this whole cycle and the byte is
      // latched at its end. A host read in this cycle is ignored so the
      // freshly captured byte is never reported as consumed.
      IN_CAPTURE: begin
        dataReg_d   = rxData_i;
        dataValid_d = 1'b1;
        state_d     = IN_ACK;
        count_d     = '0;
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    nAck_d = ~((state_d == OUT_ACK) || (state_d == IN_ACK));
    txOE_d = (state_d == OUT_SETUP) || (state_d == OUT_ACK) ||
             (state_d == OUT_RELEASE);
    rxOE_d = (state_d == IN_CAPTURE);
  end

`ifdef BEEBSCSI_PARITY_EN
  logic parityError_q, parityError_d;

  // Sticky parity error register, same reset behaviour as the rest.
  always_ff @(posedge clock_i or negedge nReset_i) begin
    if (!nReset_i) begin
      parityError_q <= 1'b0;
    end else begin
      parityError_q <= parityError_d;
    end
  end

  // A captured byte plus its parity bit must have an odd number of ones.
  // A bad capture on the same edge as a clear keeps the flag set.
  always_comb begin
    parityError_d = parityError_q;
    if (clearError_i) begin
      parityError_d = 1'b0;
    end
    if ((state_q == IN_CAPTURE) && ((^{rxData_i, dbPIn_i}) != 1'b1)) begin
      parityError_d = 1'b1;
    end
  end

  assign dbPOut_o      = ~(^dataReg_q);
  assign parityError_o = parityError_q;
`endif

  // The bus is inverted in both directions, so the invert controls are tied.
  assign txNInvert_o    = 1'b0;
  assign rxNInvert_o    = 1'b0;

  assign nACK_o         = nAck_q;
  assign txOE_o         = txOE_q;
  assign rxOE_o         = rxOE_q;
  assign dataReg_o      = dataReg_q;
  assign dataValid_o    = dataValid_q;
  assign busy_o         = (state_q != IDLE);
  assign timeoutError_o = timeoutError_q;

endmodule
